// File: rtl/ray_fifo.sv
// First-word-fall-through buffer for ray records between the AXIS adapter and the
// traversal core. Occupancy and flags come from registered pointers only.
module ray_fifo #(
    parameter int WIDTH    = 256,
    parameter int DEPTH    = 16,
    parameter int AF_LEVEL = 12
) (
    input  logic                     aclk,
    input  logic                     aresetn,
    input  logic                     write,
    input  logic [WIDTH-1:0]         din,
    output logic                     full,
    output logic                     almost_full,
    input  logic                     read,
    output logic [WIDTH-1:0]         dout,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow,
    output logic                     underflow
);
    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic [WIDTH-1:0] mem [DEPTH];
    logic             wr_en;
    logic             rd_en;

    // Extra MSB on each pointer distinguishes full from empty when indices match.
    assign empty       = (wr_ptr == rd_ptr);
    assign full        = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign count       = wr_ptr - rd_ptr;
    assign almost_full = (int'(count) >= AF_LEVEL);

    assign wr_en = write & ~full;
    assign rd_en = read & ~empty;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + 1'b1;
            if (rd_en) rd_ptr <= rd_ptr + 1'b1;
            if (write && full)  overflow  <= 1'b1;
            if (read  && empty) underflow <= 1'b1;
        end
    end

    // Storage is deliberately left out of reset; dout is meaningless while empty.
    always_ff @(posedge aclk) begin
        if (wr_en) mem[wr_ptr[AW-1:0]] <= din;
    end

    assign dout = mem[rd_ptr[AW-1:0]];

endmodule
